// File: rtl/motor_pwm_generator.sv
// Motor drive PWM generator.
// Converts a duty request in percent plus a direction into a two-wire motor drive.
// Duty/direction requests are double-buffered and only take effect at a PWM period
// boundary; a direction reversal inserts a dead-time interval with both wires low.
//
// Ports:
//   InputClock   in   1  system clock, rising edge
//   Reset        in   1  synchronous, active-low reset
//   DutyPercent  in   8  requested duty 0..100 (larger values clamp to 100)
//   Direction    in   1  0 = forward (MotorSignal[0]), 1 = reverse (MotorSignal[1])
//   Load         in   1  strobe capturing DutyPercent/Direction into the pending slot
//   LoadAck      out  1  one-cycle pulse the cycle after a Load is captured
//   MotorSignal  out  2  [0] forward drive, [1] reverse drive; never both high
//   PeriodStart  out  1  one-cycle pulse when a new PWM period begins
module motor_pwm_generator #(
  parameter int unsigned CLOCK_SCALE  = 2500,
  parameter int unsigned PERIOD_STEPS = 100,
  parameter int unsigned DEAD_TICKS   = 4
) (
  input  logic       InputClock,
  input  logic       Reset,
  input  logic [7:0] DutyPercent,
  input  logic       Direction,
  input  logic       Load,
  output logic       LoadAck,
  output logic [1:0] MotorSignal,
  output logic       PeriodStart
);

  localparam int unsigned PrescW = $clog2(CLOCK_SCALE + 1);
  localparam int unsigned StepW  = $clog2(PERIOD_STEPS + 1);
  localparam int unsigned DeadW  = $clog2(DEAD_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

  state_e           state_q;
  logic [PrescW-1:0] presc_q;
  logic [StepW-1:0]  step_q;
  logic [DeadW-1:0]  dead_q;

  // Applied duty is held pre-scaled to step units so the output compare is a plain '<'.
  logic [StepW-1:0]  scaled_q;
  logic              dir_q;

  logic [6:0]        pend_duty_q;
  logic              pend_dir_q;
  logic              pend_q;

  logic              ack_q;
  logic              pstart_q;
  logic [1:0]        motor_q;

  logic              tick;
  logic              step_last;
  logic              boundary;
  logic              dead_done;
  logic [6:0]        load_duty;
  logic [StepW-1:0]  pend_scaled;
  logic              active;
  logic [1:0]        drive;

  always_comb begin
    tick        = (presc_q == PrescW'(CLOCK_SCALE - 1));
    step_last   = (step_q == StepW'(PERIOD_STEPS - 1));
    boundary    = tick && step_last && (state_q != StDead);
    dead_done   = tick && (dead_q == DeadW'(DEAD_TICKS - 1)) && (state_q == StDead);
    load_duty   = (DutyPercent > 8'd100) ? 7'd100 : DutyPercent[6:0];
    pend_scaled = StepW'((32'(pend_duty_q) * PERIOD_STEPS) / 100);
    active      = (step_q < scaled_q);
    drive       = 2'b00;
    if (state_q == StRun) begin
      drive = dir_q ? {active, 1'b0} : {1'b0, active};
    end
  end

  always_ff @(posedge InputClock) begin
    if (!Reset) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      step_q      <= '0;
      dead_q      <= '0;
      scaled_q    <= '0;
      dir_q       <= 1'b0;
      pend_duty_q <= '0;
      pend_dir_q  <= 1'b0;
      pend_q      <= 1'b0;
      ack_q       <= 1'b0;
      pstart_q    <= 1'b0;
      motor_q     <= 2'b00;
    end else begin
      presc_q  <= tick ? '0 : presc_q + 1'b1;
      ack_q    <= Load;
      pstart_q <= boundary || dead_done;
      // Output reflects the state/step of the cycle before this edge.
      motor_q  <= drive;

      unique case (state_q)
        StIdle: begin
          if (tick) step_q <= step_last ? '0 : step_q + 1'b1;
          if (boundary && pend_q) begin
            scaled_q <= pend_scaled;
            dir_q    <= pend_dir_q;
            pend_q   <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (tick) step_q <= step_last ? '0 : step_q + 1'b1;
          if (boundary && pend_q) begin
            if (pend_dir_q == dir_q) begin
              scaled_q <= pend_scaled;
              pend_q   <= 1'b0;
            end else begin
              // Reversal: keep the request pending until dead time has elapsed.
              dead_q  <= '0;
              state_q <= StDead;
            end
          end
        end
        StDead: begin
          step_q <= '0;
          if (tick) begin
            if (dead_done) begin
              scaled_q <= pend_scaled;
              dir_q    <= pend_dir_q;
              pend_q   <= 1'b0;
              dead_q   <= '0;
              state_q  <= StRun;
            end else begin
              dead_q <= dead_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // A Load on an apply edge is captured after the older value has been consumed.
      if (Load) begin
        pend_duty_q <= load_duty;
        pend_dir_q  <= Direction;
        pend_q      <= 1'b1;
      end
    end
  end

  assign LoadAck     = ack_q;
  assign PeriodStart = pstart_q;
  assign MotorSignal = motor_q;

endmodule

// File: tb/tb_motor_pwm_generator.sv
module tb_motor_pwm_generator;

  localparam int CS       = 2;
  localparam int PSTEPS   = 10;
  localparam int DT       = 2;
  localparam int PER_CYC  = CS * PSTEPS;
  localparam int DEAD_CYC = DT * CS;

  logic       InputClock;
  logic       Reset;
  logic [7:0] DutyPercent;
  logic       Direction;
  logic       Load;
  logic       LoadAck;
  logic [1:0] MotorSignal;
  logic       PeriodStart;

  int n_checks;
  int n_fail;

  motor_pwm_generator #(
    .CLOCK_SCALE (CS),
    .PERIOD_STEPS(PSTEPS),
    .DEAD_TICKS  (DT)
  ) dut (
    .InputClock (InputClock),
    .Reset      (Reset),
    .DutyPercent(DutyPercent),
    .Direction  (Direction),
    .Load       (Load),
    .LoadAck    (LoadAck),
    .MotorSignal(MotorSignal),
    .PeriodStart(PeriodStart)
  );

  initial InputClock = 1'b0;
  always #5 InputClock = ~InputClock;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model in cycle units: position within the period, mode, applied and
  // pending requests. Outputs after an edge depend on the model state before it.
  int m_mode;  // 0 idle, 1 run, 2 dead
  int m_cyc, m_dcyc, m_duty, m_dir, m_pend, m_pduty, m_pdir;
  bit m_valid;

  initial begin
    int  e_motor, e_ack, e_ps;
    bit  l_rst, l_load, l_dir;
    int  l_duty;
    m_valid = 0;
    forever begin
      @(posedge InputClock);
      l_rst  = Reset;
      l_load = Load;
      l_duty = int'(DutyPercent);
      l_dir  = Direction;
      e_motor = 0; e_ack = 0; e_ps = 0;
      if (!l_rst) begin
        m_mode = 0; m_cyc = 0; m_dcyc = 0; m_duty = 0; m_dir = 0;
        m_pend = 0; m_pduty = 0; m_pdir = 0;
        m_valid = 1;
      end else if (m_valid) begin
        if (m_mode == 1 && m_cyc < ((m_duty * PSTEPS) / 100) * CS)
          e_motor = m_dir ? 2 : 1;
        e_ack = l_load;
        if (m_mode != 2) begin
          if (m_cyc == PER_CYC - 1) begin
            e_ps  = 1;
            m_cyc = 0;
            if (m_pend) begin
              if (m_mode == 0 || m_pdir == m_dir) begin
                m_duty = m_pduty; m_dir = m_pdir; m_pend = 0; m_mode = 1;
              end else begin
                m_mode = 2; m_dcyc = 0;
              end
            end
          end else begin
            m_cyc++;
          end
        end else begin
          if (m_dcyc == DEAD_CYC - 1) begin
            e_ps = 1;
            m_duty = m_pduty; m_dir = m_pdir; m_pend = 0; m_mode = 1; m_cyc = 0;
          end else begin
            m_dcyc++;
          end
        end
        if (l_load) begin
          m_pend  = 1;
          m_pduty = (l_duty > 100) ? 100 : l_duty;
          m_pdir  = l_dir;
        end
      end
      #1;
      if (m_valid) begin
        check("motor", int'(MotorSignal), e_motor);
        check("load_ack", int'(LoadAck), e_ack);
        check("period_start", int'(PeriodStart), e_ps);
        check("no_overlap", int'(MotorSignal == 2'b11), 0);
      end
    end
  end

  task automatic do_load(input int duty, input bit dir);
    @(negedge InputClock);
    DutyPercent = 8'(duty);
    Direction   = dir;
    Load        = 1'b1;
    @(negedge InputClock);
    Load = 1'b0;
  endtask

  // Returns on the negedge where PeriodStart is seen high; bounded.
  task automatic wait_ps(input string name, output int n);
    n = 0;
    do begin
      @(negedge InputClock);
      n++;
    end while (!PeriodStart && n < 100);
    if (!PeriodStart) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no PeriodStart within %0d cycles", name, n);
    end
  endtask

  task automatic count_hi(input int cycles, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge InputClock);
      c0 += int'(MotorSignal[0]);
      c1 += int'(MotorSignal[1]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, c1, acks, h0a, h1a, h0b, h1b;
    n_checks = 0;
    n_fail   = 0;
    Reset = 1'b0; Load = 1'b0; DutyPercent = '0; Direction = 1'b0;

    // 1. Reset and idle period cadence
    repeat (3) @(negedge InputClock);
    Reset = 1'b1;
    check("reset_motor", int'(MotorSignal), 0);
    check("reset_ack", int'(LoadAck), 0);
    wait_ps("idle_ps", n);
    wait_ps("idle_gap", n);
    check("idle_period_len", n, 20);
    count_hi(20, c0, c1);
    check("idle_hi", c0 + c1, 0);

    // 2. Forward 30%
    do_load(30, 0);
    wait_ps("fwd30_a", n);
    wait_ps("fwd30_b", n);
    count_hi(20, c0, c1);
    check("fwd30_hi0", c0, 6);
    check("fwd30_hi1", c1, 0);

    // 3. Reversal to 70% with dead time
    do_load(70, 1);
    wait_ps("rev_boundary", n);
    wait_ps("dead_len", n);
    check("dead_gap", n, 4);
    count_hi(20, c0, c1);
    check("rev70_hi0", c0, 0);
    check("rev70_hi1", c1, 14);

    // 4. Clamp and zero duty
    do_load(200, 1);
    wait_ps("clamp_a", n);
    wait_ps("clamp_b", n);
    count_hi(20, c0, c1);
    check("clamp_hi1", c1, 20);
    do_load(0, 1);
    wait_ps("zero_a", n);
    wait_ps("zero_b", n);
    count_hi(20, c0, c1);
    check("zero_hi", c0 + c1, 0);

    // 5. Two loads in a period plus one on the boundary cycle
    wait_ps("multi_sync", n);
    acks = 0; h0a = 0; h1a = 0; h0b = 0; h1b = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge InputClock);
      acks += int'(LoadAck);
      if (j >= 21 && j <= 40) begin h0a += int'(MotorSignal[0]); h1a += int'(MotorSignal[1]); end
      if (j >= 41)            begin h0b += int'(MotorSignal[0]); h1b += int'(MotorSignal[1]); end
      Direction   = 1'b1;
      Load        = (j == 2 || j == 7 || j == 19);
      DutyPercent = (j == 2) ? 8'd40 : (j == 7) ? 8'd60 : 8'd90;
    end
    check("multi_acks", acks, 3);
    check("multi_60_hi1", h1a, 12);
    check("multi_90_hi1", h1b, 18);
    check("multi_hi0", h0a + h0b, 0);

    // 6a. Reset in the middle of dead time
    do_load(50, 0);
    wait_ps("dead_enter", n);
    Reset = 1'b0;
    @(negedge InputClock);
    Reset = 1'b1;
    check("rst_dead_motor", int'(MotorSignal), 0);
    wait_ps("rst_dead_a", n);
    wait_ps("rst_dead_b", n);
    count_hi(20, c0, c1);
    check("rst_dead_idle_hi", c0 + c1, 0);

    // 6b. Reset while driving high, with a request pending
    do_load(100, 0);
    wait_ps("full_a", n);
    wait_ps("full_b", n);
    repeat (3) @(negedge InputClock);
    check("run_high_pre_reset", int'(MotorSignal), 1);
    Load = 1'b1; DutyPercent = 8'd30; Direction = 1'b1;
    @(negedge InputClock);
    Load  = 1'b0;
    Reset = 1'b0;
    @(negedge InputClock);
    Reset = 1'b1;
    check("rst_run_motor", int'(MotorSignal), 0);
    wait_ps("rst_run_a", n);
    wait_ps("rst_run_b", n);
    count_hi(20, c0, c1);
    check("rst_run_idle_hi", c0 + c1, 0);

    // 7. Randomized requests and occasional resets, checked against the model
    for (int k = 0; k < 80; k++) begin
      repeat ($urandom_range(1, 45)) @(negedge InputClock);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge InputClock);
        Reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge InputClock);
        Reset = 1'b1;
      end else begin
        do_load(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      end
    end
    repeat (100) @(negedge InputClock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
